// File: rtl/switch_pkg.sv
// Shared switch definitions: port geometry, metadata word layout, traffic
// generator FSM states and the LFSR step used for injection pacing.
package switch_pkg;

    localparam int NUM_PORTS = 4;
    localparam int PORT_W    = $clog2(NUM_PORTS);
    localparam int SEQ_W     = 12;
    localparam int TS_W      = 16;

    // Metadata word: [31:30] dst, [29:28] src, [27:16] seq, [15:0] timestamp
    typedef struct packed {
        logic [PORT_W-1:0] dst;
        logic [PORT_W-1:0] src;
        logic [SEQ_W-1:0]  seq;
        logic [TS_W-1:0]   ts;
    } meta_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } gen_state_e;

    // Right-shifting Galois form of x^32 + x^22 + x^2 + x + 1
    localparam logic [31:0] LFSR_POLY = 32'h8020_0003;

    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        return s[0] ? ((s >> 1) ^ LFSR_POLY) : (s >> 1);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: N requests -> one-hot grant. The search starts at the
// rotating pointer; after an accepted grant the pointer moves one past the
// winner so that it has lowest priority next time.
// Ports:
//   clk, reset (sync, active-low)
//   clear        pointer back to 0
//   advance      the current grant is taken; rotate the pointer
//   req[N]       request vector
//   grant[N]     one-hot grant (zero when no request)
//   grant_idx    binary index of the granted requester
//   grant_valid  some request was granted
module rr_arbiter #(
    parameter int N     = 4,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             advance,
    input  logic [N-1:0]     req,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] grant_idx,
    output logic             grant_valid
);

    logic [IDX_W-1:0] ptr_reg;
    int               idx;

    // Scan from the farthest candidate to the nearest so the last hit,
    // i.e. the one closest to the pointer, wins.
    always_comb begin
        grant       = '0;
        grant_idx   = '0;
        grant_valid = 1'b0;
        idx         = 0;
        for (int i = N - 1; i >= 0; i--) begin
            idx = int'(ptr_reg) + i;
            if (idx >= N) begin
                idx = idx - N;
            end
            if (req[idx]) begin
                grant       = '0;
                grant[idx]  = 1'b1;
                grant_idx   = IDX_W'(idx);
                grant_valid = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            ptr_reg <= '0;
        end else if (clear) begin
            ptr_reg <= '0;
        end else if (advance && grant_valid) begin
            ptr_reg <= (grant_idx == IDX_W'(N - 1)) ? '0 : grant_idx + IDX_W'(1);
        end
    end

endmodule

// File: rtl/traffic_gen.sv
// Synthetic ingress traffic source. On cfg_start it offers cfg_pkt_count
// metadata words per port, paced by an LFSR and arbitrated round-robin,
// at most one word per cycle on the shared meta bus.
// Ports:
//   clk, reset (sync, active-low)
//   cfg_start/cfg_abort   start a run / return to IDLE
//   cfg_rate, cfg_pkt_count, cfg_uniform   run config, latched at start
//   gen_in_full[p]        ingress p cannot accept; the word is dropped
//   gen_out_en, gen_out   one-hot write strobe and metadata word
//   busy, done, drop_count   status
module traffic_gen
    import switch_pkg::*;
#(
    parameter logic [31:0] LFSR_SEED = 32'hACE1_2024
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 cfg_start,
    input  logic                 cfg_abort,
    input  logic [7:0]           cfg_rate,
    input  logic [15:0]          cfg_pkt_count,
    input  logic                 cfg_uniform,
    input  logic [NUM_PORTS-1:0] gen_in_full,
    output logic [NUM_PORTS-1:0] gen_out_en,
    output logic [31:0]          gen_out,
    output logic                 busy,
    output logic                 done,
    output logic [15:0]          drop_count
);

    gen_state_e           state_reg;
    logic [31:0]          lfsr_reg;
    logic [TS_W-1:0]      ts_reg;
    logic [7:0]           rate_reg;
    logic                 uniform_reg;

    logic [NUM_PORTS-1:0] pending_vec;
    logic [NUM_PORTS-1:0] rem_zero;
    logic [SEQ_W-1:0]     seq_arr [NUM_PORTS];

    logic [NUM_PORTS-1:0] grant;
    logic [PORT_W-1:0]    grant_idx;
    logic                 grant_valid;
    meta_t                word_next;

    // Start is honoured from IDLE or DONE only; abort always wins.
    logic start_load;
    logic grant_fire;
    logic all_idle;

    assign start_load = cfg_start && !cfg_abort && (state_reg != RUN);
    assign grant_fire = (state_reg == RUN) && !cfg_abort && grant_valid;
    assign all_idle   = (pending_vec == '0) && (&rem_zero);

    rr_arbiter #(
        .N     (NUM_PORTS),
        .IDX_W (PORT_W)
    ) u_arb (
        .clk         (clk),
        .reset       (reset),
        .clear       (start_load),
        .advance     (grant_fire),
        .req         (pending_vec),
        .grant       (grant),
        .grant_idx   (grant_idx),
        .grant_valid (grant_valid)
    );

    // Per-port offer state. Pending is set from the registered LFSR byte and
    // only feeds the arbiter from the next cycle on.
    generate
        for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_port
            logic             pend_reg;
            logic [15:0]      rem_reg;
            logic [SEQ_W-1:0] seq_reg;

            always_ff @(posedge clk) begin
                if (!reset) begin
                    pend_reg <= 1'b0;
                    rem_reg  <= '0;
                    seq_reg  <= '0;
                end else if (cfg_abort) begin
                    pend_reg <= 1'b0;
                    rem_reg  <= '0;
                end else if (start_load) begin
                    pend_reg <= 1'b0;
                    rem_reg  <= cfg_pkt_count;
                    seq_reg  <= '0;
                end else if (state_reg == RUN) begin
                    if (grant_fire && grant[gi]) begin
                        pend_reg <= 1'b0;
                        rem_reg  <= rem_reg - 16'd1;
                        seq_reg  <= seq_reg + SEQ_W'(1);
                    end else if (!pend_reg && (rem_reg != '0) &&
                                 (lfsr_reg[8*gi +: 8] < rate_reg)) begin
                        pend_reg <= 1'b1;
                    end
                end
            end

            assign pending_vec[gi] = pend_reg;
            assign rem_zero[gi]    = (rem_reg == '0);
            assign seq_arr[gi]     = seq_reg;
        end
    endgenerate

    // Word for the port granted this cycle; the seq is the pre-increment value.
    always_comb begin
        word_next     = '0;
        word_next.src = grant_idx;
        word_next.seq = seq_arr[grant_idx];
        word_next.ts  = ts_reg;
        if (uniform_reg) begin
            word_next.dst = lfsr_reg[31 -: PORT_W];
        end else begin
            word_next.dst = (grant_idx == PORT_W'(NUM_PORTS - 1)) ? '0
                                                                  : grant_idx + PORT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg   <= IDLE;
            lfsr_reg    <= LFSR_SEED;
            ts_reg      <= '0;
            rate_reg    <= '0;
            uniform_reg <= 1'b0;
            gen_out_en  <= '0;
            gen_out     <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            drop_count  <= '0;
        end else begin
            ts_reg     <= ts_reg + TS_W'(1);
            gen_out_en <= '0;
            if (cfg_abort) begin
                state_reg <= IDLE;
                busy      <= 1'b0;
            end else begin
                case (state_reg)
                    IDLE, DONE: begin
                        if (cfg_start) begin
                            state_reg   <= RUN;
                            busy        <= 1'b1;
                            done        <= 1'b0;
                            rate_reg    <= cfg_rate;
                            uniform_reg <= cfg_uniform;
                            lfsr_reg    <= LFSR_SEED;
                            drop_count  <= '0;
                        end
                    end
                    RUN: begin
                        lfsr_reg <= lfsr_step(lfsr_reg);
                        if (all_idle) begin
                            state_reg <= DONE;
                            busy      <= 1'b0;
                            done      <= 1'b1;
                        end
                        if (grant_valid) begin
                            if (!gen_in_full[grant_idx]) begin
                                gen_out_en <= grant;
                                gen_out    <= word_next;
                            end else if (drop_count != 16'hFFFF) begin
                                drop_count <= drop_count + 16'd1;
                            end
                        end
                    end
                    default: begin
                        state_reg <= IDLE;
                        busy      <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_traffic_gen.sv
// Scoreboard bench for traffic_gen: expected {dst,src,seq} words are queued
// per port when a run is issued; a negedge monitor pops and compares each
// strobed word, including its timestamp against a free-running counter.
module tb_traffic_gen;
    import switch_pkg::*;

    logic                 clk = 1'b0;
    logic                 reset = 1'b0;
    logic                 cfg_start = 1'b0;
    logic                 cfg_abort = 1'b0;
    logic [7:0]           cfg_rate = '0;
    logic [15:0]          cfg_pkt_count = '0;
    logic                 cfg_uniform = 1'b0;
    logic [NUM_PORTS-1:0] gen_in_full = '0;
    logic [NUM_PORTS-1:0] gen_out_en;
    logic [31:0]          gen_out;
    logic                 busy;
    logic                 done;
    logic [15:0]          drop_count;

    traffic_gen dut (
        .clk           (clk),
        .reset         (reset),
        .cfg_start     (cfg_start),
        .cfg_abort     (cfg_abort),
        .cfg_rate      (cfg_rate),
        .cfg_pkt_count (cfg_pkt_count),
        .cfg_uniform   (cfg_uniform),
        .gen_in_full   (gen_in_full),
        .gen_out_en    (gen_out_en),
        .gen_out       (gen_out),
        .busy          (busy),
        .done          (done),
        .drop_count    (drop_count)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          passes = 0;
    int          strobes = 0;
    int          cyc = 0;
    int          start_cyc = 0;
    logic [15:0] ts_m = '0;
    logic [15:0] last_ts = '0;
    logic        wrap_seen = 1'b0;
    logic [15:0] exp_q [NUM_PORTS][$];
    int          log_n = 4;
    int          log_port [4];
    int          log_cyc [4];
    int          mon_p;
    logic [15:0] mon_e;

    // Timestamp reference: zero in reset, +1 every cycle otherwise
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!reset) ts_m <= '0;
        else        ts_m <= ts_m + 16'd1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act === req) passes++;
        else $display("FAIL %s: actual %h required %h", name, act, req);
    endtask

    function automatic int queued();
        int n = 0;
        for (int p = 0; p < NUM_PORTS; p++) n += exp_q[p].size();
        return n;
    endfunction

    task automatic flush();
        for (int p = 0; p < NUM_PORTS; p++) exp_q[p].delete();
    endtask

    // Expected words with cfg_uniform=0: dst = src+1 mod 4, seq counts from 0
    task automatic push_expect(input int count, input logic [3:0] skip);
        logic [1:0]  d;
        logic [1:0]  s;
        logic [11:0] q;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (!skip[p]) begin
                for (int i = 0; i < count; i++) begin
                    d = 2'((p + 1) % NUM_PORTS);
                    s = 2'(p);
                    q = 12'(i);
                    exp_q[p].push_back({d, s, q});
                end
            end
        end
    endtask

    // Config is scrambled after the start cycle; the DUT must have latched it.
    task automatic start_run(input logic [7:0] rate, input logic [15:0] count);
        @(posedge clk); #1;
        cfg_rate      = rate;
        cfg_pkt_count = count;
        cfg_uniform   = 1'b0;
        cfg_start     = 1'b1;
        @(posedge clk); #1;
        cfg_start     = 1'b0;
        cfg_rate      = 8'd0;
        cfg_pkt_count = 16'd0;
        cfg_uniform   = 1'b1;
        start_cyc     = cyc;
        $display("start rate=%0d count=%0d at cycle %0d", rate, count, start_cyc);
    endtask

    task automatic wait_done(input int budget);
        for (int i = 0; i < budget; i++) begin
            if (done) break;
            @(negedge clk);
        end
        check("done_reached", {31'b0, done}, 32'd1);
    endtask

    task automatic do_abort();
        @(posedge clk); #1 cfg_abort = 1'b1;
        @(posedge clk); #1 cfg_abort = 1'b0;
        @(negedge clk);
    endtask

    // Monitor: one line per strobed word, compared against the port's queue
    always @(negedge clk) begin
        if (reset && gen_out_en != '0) begin
            strobes++;
            check("strobe_onehot", 32'($countones(gen_out_en)), 32'd1);
            mon_p = 0;
            for (int i = NUM_PORTS - 1; i >= 0; i--) if (gen_out_en[i]) mon_p = i;
            $display("word port=%0d data=%h cycle=%0d", mon_p, gen_out, cyc);
            if (log_n < 4) begin
                log_port[log_n] = mon_p;
                log_cyc[log_n]  = cyc;
                log_n++;
            end
            if (exp_q[mon_p].size() == 0) begin
                checks++;
                $display("FAIL unexpected_strobe: port %0d word %h, required no strobe", mon_p, gen_out);
            end else begin
                mon_e = exp_q[mon_p].pop_front();
                check("word_dst_src_seq", {16'h0, gen_out[31:16]}, {16'h0, mon_e});
                check("word_ts", {16'h0, gen_out[15:0]}, {16'h0, 16'(ts_m - 16'd1)});
                if (gen_out[15:0] < last_ts) wrap_seen = 1'b1;
                last_ts = gen_out[15:0];
            end
        end
    end

    initial begin
        // Power-on reset
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_en", {28'b0, gen_out_en}, 32'd0);
        check("rst_out", gen_out, 32'd0);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_done", {31'b0, done}, 32'd0);
        check("rst_drop", {16'b0, drop_count}, 32'd0);
        @(posedge clk); #1 reset = 1'b1;

        // Full rate, 4 per port; first four words show rr order and latency
        strobes = 0;
        push_expect(4, 4'b0000);
        log_n = 0;
        start_run(8'd255, 16'd4);
        wait_done(100);
        @(negedge clk);
        check("t2_strobes", 32'(strobes), 32'd16);
        check("t2_busy", {31'b0, busy}, 32'd0);
        check("t2_drop", {16'b0, drop_count}, 32'd0);
        check("t2_queue_empty", 32'(queued()), 32'd0);
        for (int i = 0; i < 4; i++) begin
            check("t5_rr_port", 32'(log_port[i]), 32'(i));
            check("t5_rr_cycle", 32'(log_cyc[i]), 32'(start_cyc + 2 + i));
        end

        // Reset in the middle of a run
        push_expect(1000, 4'b0000);
        start_run(8'd255, 16'd1000);
        repeat (10) @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk);
        flush();
        @(negedge clk);
        check("t1_en", {28'b0, gen_out_en}, 32'd0);
        check("t1_out", gen_out, 32'd0);
        check("t1_busy", {31'b0, busy}, 32'd0);
        check("t1_done", {31'b0, done}, 32'd0);
        check("t1_drop", {16'b0, drop_count}, 32'd0);
        @(posedge clk);
        @(posedge clk); #1 reset = 1'b1;
        @(negedge clk);
        check("t1_en_after", {28'b0, gen_out_en}, 32'd0);
        check("t1_busy_after", {31'b0, busy}, 32'd0);

        // Zero packet count: RUN for one cycle, then DONE
        start_run(8'd255, 16'd0);
        @(negedge clk);
        check("cnt0_busy", {31'b0, busy}, 32'd1);
        @(negedge clk);
        check("cnt0_done", {31'b0, done}, 32'd1);
        check("cnt0_busy_low", {31'b0, busy}, 32'd0);

        // Rate 0: nothing injected, stays busy until abort
        strobes = 0;
        start_run(8'd0, 16'd5);
        repeat (100) @(negedge clk);
        check("t3_busy", {31'b0, busy}, 32'd1);
        check("t3_strobes", 32'(strobes), 32'd0);
        do_abort();
        check("t3_abort_busy", {31'b0, busy}, 32'd0);
        check("t3_abort_done", {31'b0, done}, 32'd0);

        // Port 2 always full: its two words are dropped
        gen_in_full = 4'b0100;
        strobes = 0;
        push_expect(2, 4'b0100);
        start_run(8'd255, 16'd2);
        wait_done(100);
        @(negedge clk);
        check("t4_strobes", 32'(strobes), 32'd6);
        check("t4_drop", {16'b0, drop_count}, 32'd2);
        check("t4_queue_empty", 32'(queued()), 32'd0);
        gen_in_full = '0;
        do_abort();
        check("t4_abort_keeps_done", {31'b0, done}, 32'd1);
        check("t4_abort_busy", {31'b0, busy}, 32'd0);

        // Long run crossing seq wrap (4095 -> 0) and timestamp wrap
        for (int i = 0; i < 70000 && ts_m != 16'd55000; i++) @(negedge clk);
        wrap_seen = 1'b0;
        last_ts   = '0;
        strobes   = 0;
        push_expect(4097, 4'b0000);
        start_run(8'd255, 16'd4097);
        wait_done(30000);
        @(negedge clk);
        check("t6_strobes", 32'(strobes), 32'd16388);
        check("t6_queue_empty", 32'(queued()), 32'd0);
        check("t6_ts_wrapped", {31'b0, wrap_seen}, 32'd1);
        check("t6_drop", {16'b0, drop_count}, 32'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
